// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job sequencer: FSM state encoding, default key width
// and the request payload carried from a requester onto the engine.
package rsa_pkg;

    localparam int RSA_WIDTH = 128;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INV_RST  = 3'd1;
    localparam logic [2:0] ST_INV_WAIT = 3'd2;
    localparam logic [2:0] ST_EXP_RST  = 3'd3;
    localparam logic [2:0] ST_EXP_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    typedef struct packed {
        logic [RSA_WIDTH-1:0]   p;
        logic [RSA_WIDTH-1:0]   q;
        logic                   encrypt_decrypt;
        logic [2*RSA_WIDTH-1:0] msg;
    } rsa_req_t;

endpackage

// File: rtl/rsa_rr_arbiter2.sv
// Two-way round-robin grant; ready is combinational on valid (zero latency) and only
// raised while enabled; the last-grant pointer moves only on an accepted request.
module rsa_rr_arbiter2 (
    input  logic clk,
    input  logic reset_n,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic ready0,
    output logic ready1,
    output logic grant,
    output logic accept
);

    logic last_grant;

    always_comb begin
        grant = valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end
    end

    assign ready0 = enable && valid0 && !grant;
    assign ready1 = enable && valid1 && grant;
    assign accept = ready0 || ready1;

    // Resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Drives one shared RSA engine (inverter, then mod_exp) for two round-robin requesters; resp_valid rises 3 cycles
// after accept plus both engine run times (2 on key reuse), holds until resp_ready; requests stall while busy. Option: RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH          = RSA_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_p,
    input  logic [WIDTH-1:0]   req0_q,
    input  logic               req0_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req0_msg,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_p,
    input  logic [WIDTH-1:0]   req1_q,
    input  logic               req1_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req1_msg,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_msg,
    output logic               resp_timeout,
    output logic [WIDTH-1:0]   eng_p,
    output logic [WIDTH-1:0]   eng_q,
    output logic               eng_encrypt_decrypt,
    output logic [2*WIDTH-1:0] eng_msg_in,
    output logic               eng_reset_inverter,
    output logic               eng_reset_mod_exp,
    input  logic               eng_inverter_finish,
    input  logic               eng_mod_exp_finish,
    input  logic [2*WIDTH-1:0] eng_msg_out,
    output logic               busy
);

    typedef struct packed {
        logic [WIDTH-1:0]   p;
        logic [WIDTH-1:0]   q;
        logic               encrypt_decrypt;
        logic [2*WIDTH-1:0] msg;
    } req_t;

    req_t             req0_pl;
    req_t             req1_pl;
    req_t             sel_pl;
    logic [2:0]       state;
    logic             guard;
    logic             key_valid;
    logic [WIDTH-1:0] key_p;
    logic [WIDTH-1:0] key_q;
    logic             key_hit;
    logic             grant;
    logic             accept;
    logic             idle;
    logic             inv_done;
    logic             exp_done;
    logic             timed_out;
    logic             timeout_fire;

    assign req0_pl = '{p: req0_p, q: req0_q, encrypt_decrypt: req0_encrypt_decrypt, msg: req0_msg};
    assign req1_pl = '{p: req1_p, q: req1_q, encrypt_decrypt: req1_encrypt_decrypt, msg: req1_msg};
    assign sel_pl  = grant ? req1_pl : req0_pl;

    assign idle    = (state == ST_IDLE);
    assign key_hit = key_valid && (sel_pl.p == key_p) && (sel_pl.q == key_q);

    rsa_rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .enable  (idle),
        .ready0  (req0_ready),
        .ready1  (req1_ready),
        .grant   (grant),
        .accept  (accept)
    );

    // The finish flags are levels left over from the previous job during the first wait cycle.
    assign inv_done = (state == ST_INV_WAIT) && !guard && eng_inverter_finish;
    assign exp_done = (state == ST_EXP_WAIT) && !guard && eng_mod_exp_finish;

    assign timeout_fire = timed_out &&
                          (((state == ST_INV_WAIT) && !inv_done) ||
                           ((state == ST_EXP_WAIT) && !exp_done));

    assign busy               = !idle;
    assign resp_valid         = (state == ST_RESP);
    assign eng_reset_inverter = (state == ST_INV_RST);
    assign eng_reset_mod_exp  = (state == ST_EXP_RST);

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset_n || (state == ST_INV_RST) || (state == ST_EXP_RST)) begin
            wait_cnt <= '0;
        end else if (((state == ST_INV_WAIT) || (state == ST_EXP_WAIT)) && !timed_out) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_timeout <= 1'b0;
        end else if (idle && accept) begin
            resp_timeout <= 1'b0;
        end else if (timeout_fire) begin
            resp_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timed_out          = 1'b0;
    assign resp_timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            guard               <= 1'b0;
            key_valid           <= 1'b0;
            key_p               <= '0;
            key_q               <= '0;
            eng_p               <= '0;
            eng_q               <= '0;
            eng_encrypt_decrypt <= 1'b0;
            eng_msg_in          <= '0;
            resp_id             <= 1'b0;
            resp_msg            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        eng_p               <= sel_pl.p;
                        eng_q               <= sel_pl.q;
                        eng_encrypt_decrypt <= sel_pl.encrypt_decrypt;
                        eng_msg_in          <= sel_pl.msg;
                        resp_id             <= grant;
                        state               <= key_hit ? ST_EXP_RST : ST_INV_RST;
                    end
                end
                ST_INV_RST: begin
                    guard <= 1'b1;
                    state <= ST_INV_WAIT;
                end
                ST_INV_WAIT: begin
                    guard <= 1'b0;
                    if (inv_done) begin
                        key_valid <= 1'b1;
                        key_p     <= eng_p;
                        key_q     <= eng_q;
                        state     <= ST_EXP_RST;
                    end else if (timeout_fire) begin
                        key_valid <= 1'b0;
                        resp_msg  <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_EXP_RST: begin
                    guard <= 1'b1;
                    state <= ST_EXP_WAIT;
                end
                ST_EXP_WAIT: begin
                    guard <= 1'b0;
                    if (exp_done) begin
                        resp_msg <= eng_msg_out;
                        state    <= ST_RESP;
                    end else if (timeout_fire) begin
                        key_valid <= 1'b0;
                        resp_msg  <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
